// File: rtl/rst_seq.sv
// rst_seq: qualifies PLL lock, then releases per-domain active-low resets one at a time with a
// programmable gap. The soft-reset handshake (HOLD/ACK) is built only when RST_SEQ_SWRST_EN is defined.
//
// state     | meaning
// ----------+------------------------------------------------------------------
// WAIT_LOCK | all domains held; counting consecutive synchronized lock-high samples
// GAP       | counting G cycles, then releasing domain idx
// RUN       | all domains released, not busy
// HOLD      | soft reset: all domains held for HOLD_CYC cycles
// ACK       | soft reset acknowledged; waits for the request to drop
module rst_seq #(
  parameter int NUM_DOM  = 4,
  parameter int LOCK_CNT = 8,
  parameter int GAP_W    = 8,
  parameter int HOLD_CYC = 16
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_pll_lock,
  input  logic [GAP_W-1:0]   i_gap,
  input  logic               i_sw_req,
  output logic               o_sw_ack,
  output logic [NUM_DOM-1:0] o_dom_rstn,
  output logic               o_busy
);

  localparam int LCK_W = $clog2(LOCK_CNT + 1);
  localparam int IDX_W = $clog2(NUM_DOM);

`ifdef RST_SEQ_SWRST_EN
  localparam int HLD_W = $clog2(HOLD_CYC + 1);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_GAP       = 3'd1,
    ST_RUN       = 3'd2,
    ST_HOLD      = 3'd3,
    ST_ACK       = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_GAP       = 2'd1,
    ST_RUN       = 2'd2
  } state_t;
`endif

  state_t             state_q, state_d;
  logic               lock_meta, lock_sync;
  logic [LCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0]   gap_len_q, gap_len_d;
  logic [GAP_W-1:0]   gap_eff;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DOM-1:0] dom_q, dom_d;
  logic               busy_q, busy_d;

`ifdef RST_SEQ_SWRST_EN
  logic               sw_req_q;
  logic               ack_q, ack_d;
  logic [HLD_W-1:0]   hold_cnt_q, hold_cnt_d;
`else
  logic               unused_sw_req;
  assign unused_sw_req = i_sw_req;
`endif

  assign gap_eff = (i_gap == '0) ? GAP_W'(1) : i_gap;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      lock_meta  <= 1'b0;
      lock_sync  <= 1'b0;
      state_q    <= ST_WAIT_LOCK;
      lock_cnt_q <= '0;
      gap_cnt_q  <= '0;
      gap_len_q  <= '0;
      idx_q      <= '0;
      dom_q      <= '0;
      busy_q     <= 1'b1;
`ifdef RST_SEQ_SWRST_EN
      sw_req_q   <= 1'b0;
      ack_q      <= 1'b0;
      hold_cnt_q <= '0;
`endif
    end else begin
      lock_meta  <= i_pll_lock;
      lock_sync  <= lock_meta;
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      gap_len_q  <= gap_len_d;
      idx_q      <= idx_d;
      dom_q      <= dom_d;
      busy_q     <= busy_d;
`ifdef RST_SEQ_SWRST_EN
      sw_req_q   <= i_sw_req;
      ack_q      <= ack_d;
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    gap_len_d  = gap_len_q;
    idx_d      = idx_q;
    dom_d      = dom_q;
`ifdef RST_SEQ_SWRST_EN
    ack_d      = ack_q;
    hold_cnt_d = hold_cnt_q;
`endif

    case (state_q)
      ST_WAIT_LOCK: begin
        if (!lock_sync) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q >= LCK_W'(LOCK_CNT - 1)) begin
          lock_cnt_d = LCK_W'(LOCK_CNT);
          gap_len_d  = gap_eff;
          gap_cnt_d  = '0;
          idx_d      = '0;
          state_d    = ST_GAP;
        end else begin
          lock_cnt_d = lock_cnt_q + LCK_W'(1);
        end
      end

      ST_GAP: begin
        if (gap_cnt_q >= gap_len_q - GAP_W'(1)) begin
          gap_cnt_d    = '0;
          dom_d[idx_q] = 1'b1;
          if (idx_q == IDX_W'(NUM_DOM - 1)) state_d = ST_RUN;
          else                              idx_d   = idx_q + IDX_W'(1);
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      ST_RUN: begin
`ifdef RST_SEQ_SWRST_EN
        if (sw_req_q) begin
          dom_d      = '0;
          hold_cnt_d = '0;
          state_d    = ST_HOLD;
        end
`endif
      end

`ifdef RST_SEQ_SWRST_EN
      ST_HOLD: begin
        if (hold_cnt_q >= HLD_W'(HOLD_CYC - 1)) begin
          hold_cnt_d = HLD_W'(HOLD_CYC);
          ack_d      = 1'b1;
          state_d    = ST_ACK;
        end else begin
          hold_cnt_d = hold_cnt_q + HLD_W'(1);
        end
      end

      ST_ACK: begin
        if (!sw_req_q) begin
          ack_d     = 1'b0;
          gap_len_d = gap_eff;
          gap_cnt_d = '0;
          idx_d     = '0;
          state_d   = ST_GAP;
        end
      end
`endif

      default: begin
        dom_d   = '0;
        state_d = ST_WAIT_LOCK;
      end
    endcase

    // Lock loss wins over every other transition on the same edge.
    if (state_q != ST_WAIT_LOCK && !lock_sync) begin
      dom_d      = '0;
      lock_cnt_d = '0;
      state_d    = ST_WAIT_LOCK;
`ifdef RST_SEQ_SWRST_EN
      ack_d      = 1'b0;
`endif
    end

    busy_d = (state_d != ST_RUN);
  end

  assign o_dom_rstn = dom_q;
  assign o_busy     = busy_q;
`ifdef RST_SEQ_SWRST_EN
  assign o_sw_ack   = ack_q;
`else
  assign o_sw_ack   = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: expected output snapshots are queued per edge number when stimulus is
// applied and compared when the simulation reaches that edge. Soft-reset tests follow RST_SEQ_SWRST_EN.
module tb_rst_seq;

  localparam int ND = 4;
  localparam int LC = 8;
  localparam int HC = 16;

  typedef struct {
    int          cyc;
    logic [ND-1:0] dom;
    logic        busy;
    logic        ack;
    string       name;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          lock = 1'b0;
  logic [7:0]    gap_in = 8'd3;
  logic          req = 1'b0;
  logic          sw_ack;
  logic [ND-1:0] dom_rstn;
  logic          busy;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  localparam logic [ND-1:0] ALL1 = '1;
  localparam logic [ND-1:0] ALL0 = '0;

  rst_seq #(.NUM_DOM(ND), .LOCK_CNT(LC), .GAP_W(8), .HOLD_CYC(HC)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_pll_lock (lock),
    .i_gap      (gap_in),
    .i_sw_req   (req),
    .o_sw_ack   (sw_ack),
    .o_dom_rstn (dom_rstn),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic void expect_at(int c, logic [ND-1:0] d, logic b, logic a, string n);
    exp_t e;
    e.cyc = c; e.dom = d; e.busy = b; e.ack = a; e.name = n;
    sb.push_back(e);
  endfunction

  // Domain i rises at t+(i+1)*g; also checks the cycle before each rise.
  function automatic void expect_release(int t, int g, string n);
    logic [ND-1:0] v;
    v = '0;
    for (int i = 0; i < ND; i++) begin
      expect_at(t + (i + 1) * g - 1, v, 1'b1, 1'b0, n);
      v[i] = 1'b1;
      expect_at(t + (i + 1) * g, v, (i == ND - 1) ? 1'b0 : 1'b1, 1'b0, n);
    end
  endfunction

  task automatic test_reset();
    exp_t e;
    repeat (3) tick();
    expect_at(cyc + 1, ALL0, 1'b1, 1'b0, "reset_values");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (dom_rstn !== e.dom || busy !== e.busy || sw_ack !== e.ack) begin
        errors++;
        $display("FAIL %s @%0d: dom=%b busy=%b ack=%b, want dom=%b busy=%b ack=%b",
                 e.name, cyc, dom_rstn, busy, sw_ack, e.dom, e.busy, e.ack);
      end
    end
    rstn = 1'b1;
    expect_at(cyc + 5, ALL0, 1'b1, 1'b0, "idle_no_lock");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (dom_rstn !== e.dom || busy !== e.busy || sw_ack !== e.ack) begin
        errors++;
        $display("FAIL %s @%0d: dom=%b busy=%b ack=%b, want dom=%b busy=%b ack=%b",
                 e.name, cyc, dom_rstn, busy, sw_ack, e.dom, e.busy, e.ack);
      end
    end
  endtask

  task automatic test_release();
    exp_t e;
    int   e_edge;
    gap_in = 8'd3;
    lock   = 1'b1;
    e_edge = cyc + 1;
    expect_at(e_edge + LC, ALL0, 1'b1, 1'b0, "qualifying");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (dom_rstn !== e.dom || busy !== e.busy || sw_ack !== e.ack) begin
        errors++;
        $display("FAIL %s @%0d: dom=%b busy=%b ack=%b, want dom=%b busy=%b ack=%b",
                 e.name, cyc, dom_rstn, busy, sw_ack, e.dom, e.busy, e.ack);
      end
    end
    tick(); tick();
    gap_in = 8'd7;  // latched G must stay 3
    expect_release(e_edge + 1 + LC, 3, "release_g3");
    expect_at(e_edge + 1 + LC + 4 * 3 + 1, ALL1, 1'b0, 1'b0, "run_steady");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (dom_rstn !== e.dom || busy !== e.busy || sw_ack !== e.ack) begin
        errors++;
        $display("FAIL %s @%0d: dom=%b busy=%b ack=%b, want dom=%b busy=%b ack=%b",
                 e.name, cyc, dom_rstn, busy, sw_ack, e.dom, e.busy, e.ack);
      end
    end
    gap_in = 8'd3;
  endtask

  task automatic test_lock_loss_run();
    exp_t e;
    int   c;
    lock = 1'b0;
    c = cyc;
    expect_at(c + 2, ALL1, 1'b0, 1'b0, "loss_run_before");
    expect_at(c + 3, ALL0, 1'b1, 1'b0, "loss_run_after");
    expect_at(c + 6, ALL0, 1'b1, 1'b0, "loss_run_held");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (dom_rstn !== e.dom || busy !== e.busy || sw_ack !== e.ack) begin
        errors++;
        $display("FAIL %s @%0d: dom=%b busy=%b ack=%b, want dom=%b busy=%b ack=%b",
                 e.name, cyc, dom_rstn, busy, sw_ack, e.dom, e.busy, e.ack);
      end
    end
  endtask

  task automatic test_lock_glitch();
    exp_t e;
    int   e1, ep;
    gap_in = 8'd3;
    lock = 1'b1;
    e1 = cyc + 1;
    repeat (5) tick();
    lock = 1'b0;
    tick();
    lock = 1'b1;
    ep = cyc + 1;
    expect_at(e1 + 1 + LC + 3, ALL0, 1'b1, 1'b0, "glitch_no_early_release");
    expect_release(ep + 1 + LC, 3, "glitch_requal");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (dom_rstn !== e.dom || busy !== e.busy || sw_ack !== e.ack) begin
        errors++;
        $display("FAIL %s @%0d: dom=%b busy=%b ack=%b, want dom=%b busy=%b ack=%b",
                 e.name, cyc, dom_rstn, busy, sw_ack, e.dom, e.busy, e.ack);
      end
    end
  endtask

  task automatic test_gap_zero();
    exp_t e;
    int   c, e_edge;
    lock = 1'b0;
    c = cyc;
    expect_at(c + 3, ALL0, 1'b1, 1'b0, "gap0_loss");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (dom_rstn !== e.dom || busy !== e.busy || sw_ack !== e.ack) begin
        errors++;
        $display("FAIL %s @%0d: dom=%b busy=%b ack=%b, want dom=%b busy=%b ack=%b",
                 e.name, cyc, dom_rstn, busy, sw_ack, e.dom, e.busy, e.ack);
      end
    end
    gap_in = 8'd0;
    lock = 1'b1;
    e_edge = cyc + 1;
    expect_release(e_edge + 1 + LC, 1, "gap0_consecutive");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (dom_rstn !== e.dom || busy !== e.busy || sw_ack !== e.ack) begin
        errors++;
        $display("FAIL %s @%0d: dom=%b busy=%b ack=%b, want dom=%b busy=%b ack=%b",
                 e.name, cyc, dom_rstn, busy, sw_ack, e.dom, e.busy, e.ack);
      end
    end
    gap_in = 8'd3;
  endtask

  task automatic test_soft_reset();
    exp_t e;
    int   s, r;
    req = 1'b1;
    s = cyc + 1;
`ifdef RST_SEQ_SWRST_EN
    expect_at(s,          ALL1, 1'b0, 1'b0, "swrst_sample_edge");
    expect_at(s + 1,      ALL0, 1'b1, 1'b0, "swrst_hold_entry");
    expect_at(s + HC,     ALL0, 1'b1, 1'b0, "swrst_hold_end");
    expect_at(s + 1 + HC, ALL0, 1'b1, 1'b1, "swrst_ack_rise");
    expect_at(s + 4 + HC, ALL0, 1'b1, 1'b1, "swrst_ack_held");
`else
    expect_at(s + 1,      ALL1, 1'b0, 1'b0, "swrst_off_ignored");
    expect_at(s + 1 + HC, ALL1, 1'b0, 1'b0, "swrst_off_no_ack");
    expect_at(s + 4 + HC, ALL1, 1'b0, 1'b0, "swrst_off_steady");
`endif
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (dom_rstn !== e.dom || busy !== e.busy || sw_ack !== e.ack) begin
        errors++;
        $display("FAIL %s @%0d: dom=%b busy=%b ack=%b, want dom=%b busy=%b ack=%b",
                 e.name, cyc, dom_rstn, busy, sw_ack, e.dom, e.busy, e.ack);
      end
    end
    gap_in = 8'd2;
    req = 1'b0;
    r = cyc + 1;
`ifdef RST_SEQ_SWRST_EN
    expect_at(r,     ALL0, 1'b1, 1'b1, "swrst_drop_edge");
    expect_at(r + 1, ALL0, 1'b1, 1'b0, "swrst_ack_fall");
    expect_release(r + 1, 2, "swrst_rerelease");
`else
    expect_at(r + 3, ALL1, 1'b0, 1'b0, "swrst_off_after_drop");
`endif
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (dom_rstn !== e.dom || busy !== e.busy || sw_ack !== e.ack) begin
        errors++;
        $display("FAIL %s @%0d: dom=%b busy=%b ack=%b, want dom=%b busy=%b ack=%b",
                 e.name, cyc, dom_rstn, busy, sw_ack, e.dom, e.busy, e.ack);
      end
    end
    gap_in = 8'd3;
  endtask

`ifdef RST_SEQ_SWRST_EN
  task automatic test_lock_loss_ack();
    exp_t e;
    int   s, c, t;
    req = 1'b1;
    s = cyc + 1;
    expect_at(s + 1 + HC, ALL0, 1'b1, 1'b1, "lossack_in_ack");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (dom_rstn !== e.dom || busy !== e.busy || sw_ack !== e.ack) begin
        errors++;
        $display("FAIL %s @%0d: dom=%b busy=%b ack=%b, want dom=%b busy=%b ack=%b",
                 e.name, cyc, dom_rstn, busy, sw_ack, e.dom, e.busy, e.ack);
      end
    end
    lock = 1'b0;
    c = cyc;
    expect_at(c + 2, ALL0, 1'b1, 1'b1, "lossack_before");
    expect_at(c + 3, ALL0, 1'b1, 1'b0, "lossack_after");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (dom_rstn !== e.dom || busy !== e.busy || sw_ack !== e.ack) begin
        errors++;
        $display("FAIL %s @%0d: dom=%b busy=%b ack=%b, want dom=%b busy=%b ack=%b",
                 e.name, cyc, dom_rstn, busy, sw_ack, e.dom, e.busy, e.ack);
      end
    end
    // Request stays high through requalification: ignored until RUN, then serviced.
    lock = 1'b1;
    t = cyc + 1 + 1 + LC;
    expect_release(t, 3, "lossack_replay");
    expect_at(t + 13, ALL0, 1'b1, 1'b0, "req_serviced_on_run");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (dom_rstn !== e.dom || busy !== e.busy || sw_ack !== e.ack) begin
        errors++;
        $display("FAIL %s @%0d: dom=%b busy=%b ack=%b, want dom=%b busy=%b ack=%b",
                 e.name, cyc, dom_rstn, busy, sw_ack, e.dom, e.busy, e.ack);
      end
    end
    req = 1'b0;
    expect_at(t + 13 + HC,     ALL0, 1'b1, 1'b1, "short_ack_rise");
    expect_at(t + 14 + HC,     ALL0, 1'b1, 1'b0, "short_ack_fall");
    expect_release(t + 14 + HC, 3, "short_ack_rerelease");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (dom_rstn !== e.dom || busy !== e.busy || sw_ack !== e.ack) begin
        errors++;
        $display("FAIL %s @%0d: dom=%b busy=%b ack=%b, want dom=%b busy=%b ack=%b",
                 e.name, cyc, dom_rstn, busy, sw_ack, e.dom, e.busy, e.ack);
      end
    end
  endtask
`endif

  task automatic test_rstn_mid();
    exp_t e;
    int   t, c;
    lock = 1'b0;
    repeat (4) tick();
    lock = 1'b1;
    t = cyc + 1 + 1 + LC;
    expect_at(t + 6, 4'b0011, 1'b1, 1'b0, "mid_seq_0011");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (dom_rstn !== e.dom || busy !== e.busy || sw_ack !== e.ack) begin
        errors++;
        $display("FAIL %s @%0d: dom=%b busy=%b ack=%b, want dom=%b busy=%b ack=%b",
                 e.name, cyc, dom_rstn, busy, sw_ack, e.dom, e.busy, e.ack);
      end
    end
    rstn = 1'b0;
    expect_at(cyc + 1, ALL0, 1'b1, 1'b0, "rstn_mid_seq");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (dom_rstn !== e.dom || busy !== e.busy || sw_ack !== e.ack) begin
        errors++;
        $display("FAIL %s @%0d: dom=%b busy=%b ack=%b, want dom=%b busy=%b ack=%b",
                 e.name, cyc, dom_rstn, busy, sw_ack, e.dom, e.busy, e.ack);
      end
    end
    tick();
    rstn = 1'b1;
    c = cyc;
    expect_at(c + 1, ALL0, 1'b1, 1'b0, "post_rstn_idle");
    expect_release(c + 1 + 1 + LC, 3, "post_rstn_release");
    expect_at(c + 2 + LC + 13, ALL1, 1'b0, 1'b0, "post_rstn_run");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (dom_rstn !== e.dom || busy !== e.busy || sw_ack !== e.ack) begin
        errors++;
        $display("FAIL %s @%0d: dom=%b busy=%b ack=%b, want dom=%b busy=%b ack=%b",
                 e.name, cyc, dom_rstn, busy, sw_ack, e.dom, e.busy, e.ack);
      end
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_lock_loss_run();
    test_lock_glitch();
    test_gap_zero();
    test_soft_reset();
`ifdef RST_SEQ_SWRST_EN
    test_lock_loss_ack();
`endif
    test_rstn_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rst_seq.md
# rst_seq

Reset release sequencer on the 100 MHz domain, directly downstream of the clock/reset manager. It consumes the manager's synchronous 100 MHz clock/reset pair and the PLL lock indication. It qualifies lock, releases a set of per-subsystem active-low resets one at a time with a programmable gap, and re-sequences on lock loss or on a software soft-reset request handshake.

## Interface
- NUM_DOM, 4: number of sequenced reset domains (2..8).
- LOCK_CNT, 8: consecutive synchronized-lock-high cycles required to qualify lock (≥2).
- GAP_W, 8: width of the gap configuration input.
- HOLD_CYC, 16: cycles all domains are held in reset during a soft reset (≥1).
- i_clk  input  1  100 MHz clock from the clock/reset manager.
- i_rstn  input  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- i_pll_lock  input  1  asynchronous PLL lock; resynchronized internally by two flops.
- i_gap  input  GAP_W  release gap G in cycles, latched on every entry into the sequence; 0 treated as 1.
- i_sw_req  input  1  soft-reset request, level, four-phase handshake.
- o_sw_ack  output  1  soft-reset acknowledge.
- o_dom_rstn  output  NUM_DOM  per-domain active-low resets, released in index order 0..NUM_DOM-1.
- o_busy  output  1  high whenever state ≠ RUN.

## Operation
- Reset values: o_dom_rstn = all 0, o_sw_ack = 0, o_busy = 1, state = WAIT_LOCK, counters = 0, sync flops = 0.
- WAIT_LOCK: lock counter clears on any synchronized-lock-low cycle and increments otherwise. On the LOCK_CNT-th consecutive high sample: latch G = max(i_gap,1), set domain index to 0, go to GAP.
- GAP: count G cycles. On the G-th cycle, drive o_dom_rstn[idx] to 1. If idx = NUM_DOM-1 go to RUN, otherwise idx+1 and stay in GAP with the counter restarted.
- RUN: all domains released, o_busy = 0. A sampled i_sw_req = 1 moves to HOLD.
- HOLD: o_dom_rstn = all 0 from the first HOLD cycle. Count HOLD_CYC cycles, then go to ACK.
- ACK: o_sw_ack = 1. Wait for i_sw_req = 0, then o_sw_ack = 0 on that edge, latch G, set idx to 0, go to GAP.
- Lock loss: synchronized lock low in GAP, RUN, HOLD or ACK forces the following on the next edge, overriding any other transition on that edge:
  - o_dom_rstn = all 0
  - o_sw_ack = 0
  - lock counter cleared
  - state = WAIT_LOCK
- i_sw_req high outside RUN is not acted on. Because it is a level, it is serviced on entry to RUN.
- Changes to i_gap mid-sequence have no effect until the next latch point.
- i_rstn low on any edge returns everything to reset values on that edge, including mid-sequence and mid-handshake.
- Counters are sized to hold LOCK_CNT, 2^GAP_W-1 and HOLD_CYC without wrap. No counter wraps; each saturates at its terminal value and is reloaded on state entry.

## Timing
- Synchronizer latency is 2 cycles. With i_pll_lock first sampled high at edge E and held high:
  - WAIT_LOCK→GAP at edge E+1+LOCK_CNT.
  - o_dom_rstn[0] rises at E+1+LOCK_CNT+G.
  - Each subsequent domain rises G cycles after the previous one.
  - o_busy falls on the same edge as the last domain release.
- Soft reset with i_sw_req sampled high at edge S in RUN:
  - o_dom_rstn all 0 and o_busy = 1 at S+1.
  - o_sw_ack rises at S+1+HOLD_CYC.
- i_sw_req low sampled at edge R while in ACK: o_sw_ack falls at R+1, then domain 0 is released G cycles later.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- RST_SEQ_SWRST_EN defined: soft-reset handshake (HOLD, ACK states, i_sw_req, o_sw_ack) is implemented as described.
- RST_SEQ_SWRST_EN undefined:
  - HOLD/ACK logic is removed.
  - i_sw_req is ignored.
  - o_sw_ack is tied to 0.
  - RUN is exited only by lock loss or i_rstn.

## Test plan
- NUM_DOM=4, LOCK_CNT=8, i_gap=3, lock rises at edge E → WAIT_LOCK exits at E+9; o_dom_rstn = 0001 at E+12, 0011 at E+15, 0111 at E+18, 1111 at E+21; o_busy falls at E+21.
- Lock glitch: lock high 5 cycles, low 1, then high → qualification restarts; o_dom_rstn[0] rises LOCK_CNT+G cycles after the final synchronized rise.
- i_gap=0 → gap treated as 1; domains released on consecutive edges.
- Soft reset (macro on), HOLD_CYC=16, req at S in RUN → o_dom_rstn = 0000 at S+1; o_sw_ack rises at S+17; req dropped at R → ack falls at R+1; full re-release follows with gap G. Macro off → req ignored, o_dom_rstn stays 1111.
- Lock loss in RUN, and lock loss during ACK → next edge o_dom_rstn = 0000, o_sw_ack = 0, o_busy = 1; sequence replays after requalification.
- i_rstn asserted while o_dom_rstn = 0011 → all outputs at reset values on that edge; sequence restarts from WAIT_LOCK after release.
